// File: rtl/uart_tx_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_monitor_if
// Brief    : Byte stream from the UART monitor FIFO (valid/ready handshake).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_monitor_if;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_monitor
// Brief    : 8N1 UART receiver feeding a small byte FIFO, with sticky halt flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_monitor #(
    parameter int         CLKS_PER_BIT = 868,
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [7:0] HALT_BYTE    = 8'h00
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx,
    uart_tx_monitor_if.master        out_if,
    output logic                     frame_err,
    output logic                     overflow,
    output logic                     busy,
    output logic                     halt,
    output logic [31:0]              byte_count
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);

    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_bit  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
    localparam logic [c_ptr_w:0]   c_lvl_one  = (c_ptr_w + 1)'(1);
    localparam logic [c_ptr_w:0]   c_lvl_full = (c_ptr_w + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    logic               r_rx_meta;
    logic               r_rx_s;
    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_level;

    logic               r_frame_err;
    logic               r_overflow;
    logic               r_halt;
    logic [31:0]        r_byte_count;

    logic w_tick;
    logic w_push;
    logic w_bad;
    logic w_valid;
    logic w_pop;
    logic w_full;
    logic w_accept;

    assign w_tick   = (r_cnt == '0);
    assign w_push   = (r_state == c_stop) && w_tick && r_rx_s;
    assign w_bad    = (r_state == c_stop) && w_tick && !r_rx_s;
    assign w_valid  = (r_level != '0);
    assign w_pop    = w_valid && out_if.out_ready;
    assign w_full   = (r_level == c_lvl_full);
    // A pop on the same edge frees the slot the push needs.
    assign w_accept = w_push && (!w_full || w_pop);

    // rx is asynchronous to clk; idle-high preset avoids a false start after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_idle;
            r_cnt     <= '0;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
        end else begin
            case (r_state)
                c_idle: begin
                    if (!r_rx_s) begin
                        r_state <= c_start;
                        r_cnt   <= c_cnt_half;
                    end
                end
                c_start: begin
                    if (w_tick) begin
                        if (r_rx_s) begin
                            r_state <= c_idle;
                        end else begin
                            r_state   <= c_data;
                            r_cnt     <= c_cnt_bit;
                            r_bit_cnt <= 3'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                c_data: begin
                    if (w_tick) begin
                        r_shift <= {r_rx_s, r_shift[7:1]};
                        r_cnt   <= c_cnt_bit;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= c_stop;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                c_stop: begin
                    if (w_tick) begin
                        r_state <= c_idle;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= r_shift;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_frame_err  <= 1'b0;
            r_overflow   <= 1'b0;
            r_halt       <= 1'b0;
            r_byte_count <= 32'd0;
        end else begin
            r_frame_err <= w_bad;
            r_overflow  <= w_push && !w_accept;
            // Dropped bytes still count and can still raise halt.
            if (w_push) begin
                r_byte_count <= r_byte_count + 32'd1;
                if (r_shift == HALT_BYTE) begin
                    r_halt <= 1'b1;
                end
            end
            if (w_accept) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_accept, w_pop})
                2'b10:   r_level <= r_level + c_lvl_one;
                2'b01:   r_level <= r_level - c_lvl_one;
                default: r_level <= r_level;
            endcase
        end
    end

    assign out_if.out_valid = w_valid;
    assign out_if.out_data  = w_valid ? r_mem[r_rd_ptr] : 8'h00;
    assign frame_err        = r_frame_err;
    assign overflow         = r_overflow;
    assign busy             = (r_state != c_idle);
    assign halt             = r_halt;
    assign byte_count       = r_byte_count;

endmodule
`default_nettype wire
